// File: rtl/rtl_pit_if.sv
// rtl_pit_if: 6502-style bus strobes between a CPU (or bench) and rtl_pit.
//
// Signals:
//   E      bus phase (PHI2); a bus cycle is valid while high
//   CS_N   chip select, active low
//   RS     register select (ABUS[1:0])
//   RW_N   1 = read, 0 = write
//   IRQ_N  interrupt request back to the CPU, active low
//
// Bus protocol (the only handshake on this block): a cycle is "valid" while
// E=1 with CS_N=0. There is no ready/stall: the timer always accepts. A write
// takes effect once, when E drops, with the strobes and data seen on the last
// E=1 clock. A read is answered combinationally for as long as E=1, CS_N=0
// and RW_N=1. The bidirectional data bus is a plain port on rtl_pit so that
// the tristate net resolves at the module boundary.
//
// Modports: master drives strobes and watches IRQ_N; slave is the timer.
interface rtl_pit_if;
  logic       E;
  logic       CS_N;
  logic [1:0] RS;
  logic       RW_N;
  logic       IRQ_N;

  modport master (output E, output CS_N, output RS, output RW_N, input IRQ_N);
  modport slave  (input E, input CS_N, input RS, input RW_N, output IRQ_N);
endinterface

// File: rtl/rtl_pit.sv
// rtl_pit: memory-mapped programmable interval timer for a 6502 bus.
// A prescaler divides CLK by SYSCLK_MHZ into a 1 us tick; a 16-bit counter
// decrements on each tick and sets FLAG on underflow, optionally reloading
// from the latch. IRQ_N is the registered inverse of FLAG & IRQEN.
//
// Registers (RS):
//   0 CTRL   R/W  bit0 EN, bit1 CONT, bit2 IRQEN
//   1 STATUS R: bit7 FLAG, bit0 EN   W: bit7=1 clears FLAG
//   2 LO     W: latch[7:0]           R: count[7:0]
//   3 HI     W: latch[15:8], load count, restart prescaler, clear FLAG, EN=1
//            R: count[15:8] (or the snapshot, see below)
//
// Ports:
//   CLK    system clock, rising edge
//   RESET  asynchronous, active-high reset
//   bus    rtl_pit_if.slave (E, CS_N, RS, RW_N in; IRQ_N out)
//   DIO    8-bit bidirectional data bus, driven only during selected reads
//
// Parameter: SYSCLK_MHZ - CLK frequency in MHz (prescaler modulus).
// Build option: define PIT_SNAPSHOT_EN to add a snapshot register that
// captures count[15:8] when a LO read completes; HI reads then return it so
// LO-then-HI gives a coherent 16-bit value.
module rtl_pit #(
  parameter int SYSCLK_MHZ = 27
) (
  input  logic       CLK,
  input  logic       RESET,
  rtl_pit_if.slave   bus,
  inout  wire  [7:0] DIO
);

  localparam int PW = (SYSCLK_MHZ > 1) ? $clog2(SYSCLK_MHZ) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(SYSCLK_MHZ - 1);

  // Bus capture: strobes/data are held from the last E=1 clock so the
  // commit on the falling edge of registered E sees stable values.
  logic       e_q;
  logic       cs_n_q;
  logic       rw_n_q;
  logic [1:0] rs_q;
  logic [7:0] din_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      e_q    <= 1'b0;
      cs_n_q <= 1'b1;
      rw_n_q <= 1'b1;
      rs_q   <= 2'd0;
      din_q  <= 8'h00;
    end else begin
      e_q <= bus.E;
      if (bus.E) begin
        cs_n_q <= bus.CS_N;
        rw_n_q <= bus.RW_N;
        rs_q   <= bus.RS;
        din_q  <= DIO;
      end
    end
  end

  logic commit;
  logic wr_sel;
  logic wr_ctrl;
  logic wr_status;
  logic wr_lo;
  logic wr_hi;

  assign commit    = e_q & ~bus.E;
  assign wr_sel    = commit & ~cs_n_q & ~rw_n_q;
  assign wr_ctrl   = wr_sel & (rs_q == 2'd0);
  assign wr_status = wr_sel & (rs_q == 2'd1);
  assign wr_lo     = wr_sel & (rs_q == 2'd2);
  assign wr_hi     = wr_sel & (rs_q == 2'd3);

  // Timer state
  logic          en;
  logic          cont;
  logic          irqen;
  logic          flag;
  logic [PW-1:0] presc;
  logic [15:0]   latch;
  logic [15:0]   count;
  logic          irq_n_q;

  logic tick;
  logic underflow;

  assign tick      = en & (presc == PRESC_TOP);
  assign underflow = tick & (count == 16'h0000);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      en      <= 1'b0;
      cont    <= 1'b0;
      irqen   <= 1'b0;
      flag    <= 1'b0;
      presc   <= '0;
      latch   <= 16'hFFFF;
      count   <= 16'hFFFF;
      irq_n_q <= 1'b1;
    end else begin
      // Prescaler: restarted by a HI load, parked at 0 while stopped.
      if (wr_hi || !en || tick) presc <= '0;
      else                      presc <= presc + PW'(1);

      if (wr_lo) latch[7:0]  <= din_q;
      if (wr_hi) latch[15:8] <= din_q;

      // A HI load overrides whatever the tick would have done this edge.
      if (wr_hi) begin
        count <= {din_q, latch[7:0]};
      end else if (tick) begin
        if (count != 16'h0000) count <= count - 16'd1;
        else if (cont)         count <= latch;
      end

      // EN: CTRL write beats a one-shot underflow; HI load always starts.
      if (wr_ctrl) begin
        en    <= din_q[0];
        cont  <= din_q[1];
        irqen <= din_q[2];
      end else if (wr_hi) begin
        en <= 1'b1;
      end else if (underflow && !cont) begin
        en <= 1'b0;
      end

      // FLAG: HI load clears over underflow; underflow sets over W1C.
      if (wr_hi)                         flag <= 1'b0;
      else if (underflow)                flag <= 1'b1;
      else if (wr_status && din_q[7])    flag <= 1'b0;

      irq_n_q <= ~(flag & irqen);
    end
  end

  logic [7:0] hi_byte;

`ifdef PIT_SNAPSHOT_EN
  logic       rd_lo_done;
  logic [7:0] snap;

  assign rd_lo_done = commit & ~cs_n_q & rw_n_q & (rs_q == 2'd2);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)           snap <= 8'h00;
    else if (rd_lo_done) snap <= count[15:8];
  end

  assign hi_byte = snap;
`else
  assign hi_byte = count[15:8];
`endif

  // Read path is purely combinational on the live bus strobes.
  logic [7:0] rdata;
  logic       rd_drive;

  always_comb begin
    rdata = 8'h00;
    case (bus.RS)
      2'd0:    rdata = {5'b00000, irqen, cont, en};
      2'd1:    rdata = {flag, 6'b000000, en};
      2'd2:    rdata = count[7:0];
      default: rdata = hi_byte;
    endcase
  end

  assign rd_drive  = bus.E & ~bus.CS_N & bus.RW_N;
  assign DIO       = rd_drive ? rdata : 8'hzz;
  assign bus.IRQ_N = irq_n_q;

endmodule

// File: tb/tb_rtl_pit.sv
// tb_rtl_pit: self-checking bench for rtl_pit (SYSCLK_MHZ = 27).
// Expected values are pushed to a scoreboard queue as each stimulus is
// driven and popped when the DUT answers (bus read data, IRQ_N level or an
// IRQ_N edge latency in CLK cycles). Honours PIT_SNAPSHOT_EN if defined.
module tb_rtl_pit;

  localparam int SYSCLK_MHZ = 27;

`ifdef PIT_SNAPSHOT_EN
  localparam logic [7:0] HI_AT_RESET = 8'h00;
  localparam logic [7:0] HI_AFTER_CROSS = 8'h01;
`else
  localparam logic [7:0] HI_AT_RESET = 8'hFF;
  localparam logic [7:0] HI_AFTER_CROSS = 8'h00;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  rtl_pit_if bus ();
  tri1 [7:0] dio;
  logic       tb_oe;
  logic [7:0] tb_dout;
  assign dio = tb_oe ? tb_dout : 8'hzz;

  rtl_pit #(.SYSCLK_MHZ(SYSCLK_MHZ)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus),
    .DIO   (dio)
  );

  // Scoreboard
  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];
  int unsigned commit_cyc;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [15:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [15:0] got);
    string       t;
    logic [15:0] e;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    check(t, got, e);
  endtask

  // Driver tasks
  task automatic bus_idle();
    bus.E = 1'b0; bus.CS_N = 1'b1; bus.RW_N = 1'b1; bus.RS = 2'd0;
    tb_oe = 1'b0; tb_dout = 8'h00;
  endtask

  // Commit lands on the posedge right after this task returns.
  task automatic bus_write(input logic [1:0] rs, input logic [7:0] data);
    @(negedge clk);
    bus.E = 1'b1; bus.CS_N = 1'b0; bus.RW_N = 1'b0; bus.RS = rs;
    tb_oe = 1'b1; tb_dout = data;
    @(negedge clk);
    bus.E = 1'b0; bus.CS_N = 1'b1; bus.RW_N = 1'b1; tb_oe = 1'b0;
    commit_cyc = cyc_cnt + 1;
  endtask

  task automatic bus_probe(input logic e, input logic cs_n, input logic [1:0] rs,
                           output logic [7:0] data);
    @(negedge clk);
    bus.E = e; bus.CS_N = cs_n; bus.RW_N = 1'b1; bus.RS = rs;
    #2 data = dio;
    @(negedge clk);
    bus.E = 1'b0; bus.CS_N = 1'b1;
  endtask

  task automatic read_expect(input string tag, input logic [1:0] rs, input logic [7:0] exp);
    logic [7:0] d;
    sb_push(tag, {8'h00, exp});
    bus_probe(1'b1, 1'b0, rs, d);
    sb_pop({8'h00, d});
  endtask

  task automatic irq_expect(input string tag, input logic exp);
    sb_push(tag, {15'b0, exp});
    sb_pop({15'b0, bus.IRQ_N});
  endtask

  // Returns the cycle index of the first posedge after which IRQ_N==level.
  task automatic wait_irq(input logic level, input int limit, output int unsigned at);
    at = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (bus.IRQ_N === level) begin
        at = cyc_cnt;
        break;
      end
    end
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc_cnt < c) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t1, t2, f3, commit_hi, u;
    logic [7:0]  d;

    rst = 1'b1;
    bus_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state and idle bus
    irq_expect("rst_irq_n", 1'b1);
    read_expect("rst_ctrl", 2'd0, 8'h00);
    read_expect("rst_status", 2'd1, 8'h00);
    read_expect("rst_hi", 2'd3, HI_AT_RESET);
    read_expect("rst_lo", 2'd2, 8'hFF);
    sb_push("dio_z_cs_high", 16'h00FF);
    bus_probe(1'b1, 1'b1, 2'd0, d);
    sb_pop({8'h00, d});
    sb_push("dio_z_e_low", 16'h00FF);
    bus_probe(1'b0, 1'b0, 2'd0, d);
    sb_pop({8'h00, d});

    // One-shot, N=4: underflow 135 CLK after commit, IRQ_N one later
    bus_write(2'd0, 8'h04);
    bus_write(2'd2, 8'h04);
    bus_write(2'd3, 8'h00);
    sb_push("oneshot_irq_lat", 16'd136);
    wait_irq(1'b0, 400, t1);
    sb_pop(16'(t1 - commit_cyc));
    read_expect("oneshot_status", 2'd1, 8'h80);
    read_expect("oneshot_lo", 2'd2, 8'h00);
    repeat (60) @(negedge clk);
    read_expect("oneshot_lo_hold", 2'd2, 8'h00);
    read_expect("oneshot_hi_hold", 2'd3, 8'h00);
    bus_write(2'd1, 8'h80);
    sb_push("oneshot_irq_release", 16'd1);
    wait_irq(1'b1, 10, t1);
    sb_pop(16'(t1 - commit_cyc));

    // Continuous, N=2: FLAG every 81 CLK, reload to 2
    bus_write(2'd0, 8'h06);
    bus_write(2'd2, 8'h02);
    bus_write(2'd3, 8'h00);
    sb_push("cont_first_lat", 16'd82);
    wait_irq(1'b0, 300, t1);
    sb_pop(16'(t1 - commit_cyc));
    bus_write(2'd1, 8'h80);
    sb_push("cont_irq_release", 16'd1);
    wait_irq(1'b1, 10, t2);
    sb_pop(16'(t2 - commit_cyc));
    read_expect("cont_reload_lo", 2'd2, 8'h02);
    sb_push("cont_period", 16'd81);
    wait_irq(1'b0, 200, t2);
    sb_pop(16'(t2 - t1));
    read_expect("cont_status", 2'd1, 8'h81);

    // HI write on the underflow edge: write wins, FLAG ends 0
    bus_write(2'd2, 8'h05);
    f3 = t2 - 1 + 81;
    wait_until(f3 - 3);
    bus_write(2'd3, 8'h01);
    commit_hi = commit_cyc;
    read_expect("hiprec_status", 2'd1, 8'h01);
    read_expect("hiprec_lo", 2'd2, 8'h05);
    read_expect("hiprec_hi", 2'd3, 8'h01);
    irq_expect("hiprec_irq_n", 1'b1);

    // STATUS clear on the underflow edge: set wins, FLAG ends 1
    u = commit_hi + (16'h0105 + 1) * SYSCLK_MHZ;
    wait_until(u - 3);
    bus_write(2'd1, 8'h80);
    read_expect("clrprec_status", 2'd1, 8'h81);
    read_expect("clrprec_reload_lo", 2'd2, 8'h05);
    irq_expect("clrprec_irq_n", 1'b0);

    // Snapshot coherence across the 0x0100 -> 0x00FF crossing
    bus_write(2'd0, 8'h00);
    bus_write(2'd1, 8'h80);
    bus_write(2'd2, 8'h00);
    bus_write(2'd3, 8'h01);
    read_expect("snap_lo_first", 2'd2, 8'h00);
    repeat (40) @(negedge clk);
    read_expect("snap_hi_after_cross", 2'd3, HI_AFTER_CROSS);
    read_expect("snap_lo_after_cross", 2'd2, 8'hFF);

    // N=0 continuous: first underflow on the first tick, IRQ_N held low
    bus_write(2'd0, 8'h06);
    bus_write(2'd2, 8'h00);
    bus_write(2'd3, 8'h00);
    sb_push("n0_irq_lat", 16'd28);
    wait_irq(1'b0, 100, t1);
    sb_pop(16'(t1 - commit_cyc));

    // Reset mid-count with a CTRL write in flight
    @(negedge clk);
    bus.E = 1'b1; bus.CS_N = 1'b0; bus.RW_N = 1'b0; bus.RS = 2'd0;
    tb_oe = 1'b1; tb_dout = 8'h07;
    @(negedge clk);
    irq_expect("pre_rst_irq_n", 1'b0);
    #2 rst = 1'b1;
    #1 irq_expect("rst_async_irq_n", 1'b1);
    bus_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    read_expect("rst2_ctrl", 2'd0, 8'h00);
    read_expect("rst2_status", 2'd1, 8'h00);
    read_expect("rst2_hi", 2'd3, HI_AT_RESET);
    read_expect("rst2_lo", 2'd2, 8'hFF);
    repeat (30) @(negedge clk);
    read_expect("rst2_lo_idle", 2'd2, 8'hFF);
    irq_expect("rst2_irq_n", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
